// File: rtl/pi_ctrl_pkg.sv
// Shared types and defaults for the time-multiplexed PI current controller.
// Holds the FSM state encoding, default parameter values and the channel slice helper.
package pi_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ERR,
    MULP,
    MULI,
    OUT,
    DONE
  } stateT;

  localparam int CH_DEF   = 2;
  localparam int DW_DEF   = 12;
  localparam int KW_DEF   = 16;
  localparam int FRAC_DEF = 12;
  localparam int OW_DEF   = 16;
  localparam int IW_DEF   = 32;

  // Bit offset of channel c inside a bus packed with w bits per channel.
  function automatic int chOff(input int c, input int w);
    return c * w;
  endfunction

endpackage

// File: rtl/sat_signed.sv
// Symmetric signed saturator: clamps iVal to [-iLim, +iLim] and flags when it clipped.
// Combinational; iLim must be non-negative and representable in OUT_W signed bits.
module sat_signed #(
  parameter int IN_W  = 17,
  parameter int OUT_W = 16,
  parameter int LIM_W = 16
) (
  input  logic signed [IN_W-1:0]  iVal,
  input  logic signed [LIM_W-1:0] iLim,
  output logic signed [OUT_W-1:0] oVal,
  output logic                    oClip
);

  localparam int CW = ((IN_W > LIM_W) ? IN_W : LIM_W) + 1;

  logic signed [CW-1:0] valX;
  logic signed [CW-1:0] limX;
  logic signed [CW-1:0] limN;

  always_comb begin
    valX  = {{(CW-IN_W){iVal[IN_W-1]}}, iVal};
    limX  = {{(CW-LIM_W){iLim[LIM_W-1]}}, iLim};
    limN  = -limX;
    oVal  = valX[OUT_W-1:0];
    oClip = 1'b0;
    if (valX > limX) begin
      oVal  = limX[OUT_W-1:0];
      oClip = 1'b1;
    end else if (valX < limN) begin
      oVal  = limN[OUT_W-1:0];
      oClip = 1'b1;
    end
  end

endmodule

// File: rtl/pi_ctrl_mc.sv
// Multi-channel PI controller sharing one multiplier; 4 cycles per channel, result strobe 4*CH+1 cycles after start.
// Starts while busy are dropped; PI_CTRL_ANTIWINDUP_EN clamps each integrator to +/-(L<<FRAC).
module pi_ctrl_mc
  import pi_ctrl_pkg::*;
#(
  parameter int CH   = CH_DEF,
  parameter int DW   = DW_DEF,
  parameter int KW   = KW_DEF,
  parameter int FRAC = FRAC_DEF,
  parameter int OW   = OW_DEF,
  parameter int IW   = IW_DEF
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iCal_en,
  input  logic [CH*DW-1:0]  iTarget,
  input  logic [CH*DW-1:0]  iCurrent,
  input  logic [CH*KW-1:0]  iKp,
  input  logic [CH*KW-1:0]  iKi,
  input  logic [OW-2:0]     iOut_max,
  input  logic              iClr_int,
  output logic [CH*OW-1:0]  oCal,
  output logic              oCal_done,
  output logic              oBusy,
  output logic [CH-1:0]     oSat
);

  localparam int EW = DW + 1;
  localparam int PW = KW + DW + 2;
  localparam int SW = ((PW > IW) ? PW : IW) + 1;
  localparam int UW = SW - FRAC;
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
`ifdef PI_CTRL_ANTIWINDUP_EN
  localparam int LIW = OW + FRAC;
`else
  localparam int LIW = IW;
`endif

  stateT state, stateNxt;
  logic [CW-1:0]      ch;
  logic [CH*DW-1:0]   tgtR, curR;
  logic [CH*KW-1:0]   kpR, kiR;
  logic [OW-2:0]      limR;
  logic signed [EW-1:0] errR;
  logic signed [PW-1:0] pR;
  logic signed [IW-1:0] integ [CH];
  logic [CH*OW-1:0]   shadow, shadowNxt, calR;
  logic [CH-1:0]      satShadow, satNxt, satR;
  logic               clrPend;

  logic signed [DW-1:0]  tgtC, curC;
  logic [KW-1:0]         gainC;
  logic signed [EW-1:0]  errC;
  logic signed [PW-1:0]  gainX, errX, prod;
  logic signed [IW-1:0]  integC, integSat;
  logic signed [IW:0]    integSum;
  logic signed [LIW-1:0] integLim;
  logic signed [SW-1:0]  uSum;
  logic signed [UW-1:0]  uFloor;
  logic signed [OW-1:0]  outLim, yC;
  logic                  clipC;

  assign tgtC   = tgtR[chOff(int'(ch), DW) +: DW];
  assign curC   = curR[chOff(int'(ch), DW) +: DW];
  assign errC   = {tgtC[DW-1], tgtC} - {curC[DW-1], curC};
  assign integC = integ[ch];

  // Single shared multiplier: Kp in MULP, Ki in MULI, always against the latched error.
  assign gainC = (state == MULI) ? kiR[chOff(int'(ch), KW) +: KW] : kpR[chOff(int'(ch), KW) +: KW];
  assign gainX = {{(PW-KW){1'b0}}, gainC};
  assign errX  = {{(PW-EW){errR[EW-1]}}, errR};
  assign prod  = gainX * errX;

  assign integSum = {integC[IW-1], integC} + {{(IW+1-PW){prod[PW-1]}}, prod};
`ifdef PI_CTRL_ANTIWINDUP_EN
  assign integLim = {1'b0, limR, {FRAC{1'b0}}};
`else
  assign integLim = {1'b0, {(IW-1){1'b1}}};
`endif

  sat_signed #(.IN_W(IW+1), .OUT_W(IW), .LIM_W(LIW)) uIntSat (
    .iVal  (integSum),
    .iLim  (integLim),
    .oVal  (integSat),
    .oClip ()
  );

  // Taking the upper bits of the sum is an arithmetic shift, i.e. floor toward -inf.
  assign uSum   = {{(SW-PW){pR[PW-1]}}, pR} + {{(SW-IW){integC[IW-1]}}, integC};
  assign uFloor = uSum[SW-1:FRAC];
  assign outLim = {1'b0, limR};

  sat_signed #(.IN_W(UW), .OUT_W(OW), .LIM_W(OW)) uOutSat (
    .iVal  (uFloor),
    .iLim  (outLim),
    .oVal  (yC),
    .oClip (clipC)
  );

  always_comb begin
    shadowNxt = shadow;
    satNxt    = satShadow;
    shadowNxt[chOff(int'(ch), OW) +: OW] = yC;
    satNxt[ch] = clipC;
  end

  always_comb begin
    stateNxt  = state;
    oBusy     = (state != IDLE);
    oCal_done = 1'b0;
    oCal      = calR;
    oSat      = satR;
    case (state)
      IDLE: if (iCal_en) stateNxt = ERR;
      ERR:  stateNxt = MULP;
      MULP: stateNxt = MULI;
      MULI: stateNxt = OUT;
      OUT:  stateNxt = (ch == CW'(CH-1)) ? DONE : ERR;
      DONE: begin
        stateNxt  = IDLE;
        oCal_done = 1'b1;
        oCal      = shadow;
        oSat      = satShadow;
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state     <= IDLE;
      ch        <= '0;
      tgtR      <= '0;
      curR      <= '0;
      kpR       <= '0;
      kiR       <= '0;
      limR      <= '0;
      errR      <= '0;
      pR        <= '0;
      shadow    <= '0;
      satShadow <= '0;
      calR      <= '0;
      satR      <= '0;
      clrPend   <= 1'b0;
      for (int i = 0; i < CH; i++) integ[i] <= '0;
    end else begin
      state <= stateNxt;
      case (state)
        IDLE: begin
          // A clear arriving with a start is applied first so the run sees I = 0.
          if (iClr_int || clrPend) begin
            for (int i = 0; i < CH; i++) integ[i] <= '0;
          end
          clrPend <= 1'b0;
          if (iCal_en) begin
            tgtR <= iTarget;
            curR <= iCurrent;
            kpR  <= iKp;
            kiR  <= iKi;
            limR <= iOut_max;
            ch   <= '0;
          end
        end
        ERR:  errR <= errC;
        MULP: pR <= prod;
        MULI: integ[ch] <= integSat;
        OUT: begin
          shadow    <= shadowNxt;
          satShadow <= satNxt;
          ch        <= ch + CW'(1);
        end
        DONE: begin
          calR <= shadow;
          satR <= satShadow;
        end
        default: ;
      endcase
      if (state != IDLE && iClr_int) clrPend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pi_ctrl_mc.sv
// Directed bench for pi_ctrl_mc (CH=2, DW=12, KW=16, FRAC=12, OW=16, IW=32).
// Expected values are hand-derived; anti-windup dependent values follow PI_CTRL_ANTIWINDUP_EN.
module tb_pi_ctrl_mc;

`ifdef PI_CTRL_ANTIWINDUP_EN
  localparam bit AW = 1'b1;
`else
  localparam bit AW = 1'b0;
`endif

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iCal_en;
  logic [23:0] iTarget, iCurrent;
  logic [31:0] iKp, iKi;
  logic [14:0] iOut_max;
  logic        iClr_int;
  logic [31:0] oCal;
  logic        oCal_done;
  logic        oBusy;
  logic [1:0]  oSat;

  int total = 0;
  int bad = 0;
  int lastLat;
  logic doneAfter;
  int strobes;

  pi_ctrl_mc dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iCal_en   (iCal_en),
    .iTarget   (iTarget),
    .iCurrent  (iCurrent),
    .iKp       (iKp),
    .iKi       (iKi),
    .iOut_max  (iOut_max),
    .iClr_int  (iClr_int),
    .oCal      (oCal),
    .oCal_done (oCal_done),
    .oBusy     (oBusy),
    .oSat      (oSat)
  );

  always #5 iClk = ~iClk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [31:0] outCh(input int c);
    logic signed [15:0] v;
    v = oCal[c*16 +: 16];
    return v;
  endfunction

  task automatic setCh(input int c, input int t, input int cu, input int kp, input int ki);
    iTarget[c*12 +: 12]  = t[11:0];
    iCurrent[c*12 +: 12] = cu[11:0];
    iKp[c*16 +: 16]      = kp[15:0];
    iKi[c*16 +: 16]      = ki[15:0];
  endtask

  // Start one computation, wait (bounded) for the strobe, then step into IDLE.
  task automatic runCal(input logic clr, input logic midClr);
    int k;
    iCal_en  = 1'b1;
    iClr_int = clr;
    @(posedge iClk); #1;
    iCal_en  = 1'b0;
    iClr_int = 1'b0;
    k = 1;
    while (!oCal_done && k < 20) begin
      iClr_int = (midClr && k == 3);
      @(posedge iClk); #1;
      k++;
    end
    iClr_int = 1'b0;
    lastLat = k;
    check("strobe_seen", oCal_done, 1);
    @(posedge iClk); #1;
    doneAfter = oCal_done;
  endtask

  initial begin
    iRst = 1'b1; iCal_en = 1'b0; iClr_int = 1'b0;
    iTarget = '0; iCurrent = '0; iKp = '0; iKi = '0; iOut_max = 15'd3000;
    repeat (3) @(posedge iClk);
    #1;
    check("rst_cal", oCal, 0);
    check("rst_done", oCal_done, 0);
    check("rst_busy", oBusy, 0);
    check("rst_sat", oSat, 0);
    iRst = 1'b0;
    @(posedge iClk); #1;

    // P-only; ch1 exercises floor of a negative fraction: 0.5 * -3 = -1.5 -> -2
    setCh(0, 100, 40, 4096, 0);
    setCh(1, 0, 3, 2048, 0);
    iOut_max = 15'd3000;
    runCal(1'b1, 1'b0);
    check("p_latency", lastLat, 9);
    check("p_out0", outCh(0), 60);
    check("p_out1_floor", outCh(1), -2);
    check("p_sat", oSat, 0);
    check("p_done_one_cycle", doneAfter, 0);
    check("p_busy_after", oBusy, 0);
    repeat (5) @(posedge iClk);
    #1;
    check("p_hold", outCh(0), 60);

    // Integrator: 0.5 * 10 per update
    setCh(0, 0, 0, 0, 0);
    setCh(1, 10, 0, 0, 2048);
    runCal(1'b1, 1'b0);
    check("i_run1", outCh(1), 5);
    runCal(1'b0, 1'b0);
    check("i_run2", outCh(1), 10);
    runCal(1'b0, 1'b0);
    check("i_run3", outCh(1), 15);
    check("i_out0", outCh(0), 0);

    // Reset mid-computation: nothing published, integrators zeroed
    iCal_en = 1'b1;
    @(posedge iClk); #1;
    iCal_en = 1'b0;
    repeat (3) @(posedge iClk);
    #1;
    iRst = 1'b1;
    @(posedge iClk); #1;
    check("mrst_busy", oBusy, 0);
    check("mrst_done", oCal_done, 0);
    check("mrst_cal", oCal, 0);
    check("mrst_sat", oSat, 0);
    iRst = 1'b0;
    runCal(1'b0, 1'b0);
    check("mrst_integ_zero", outCh(1), 5);

    // Saturation with full-scale errors (+/-4095)
    setCh(0, 2047, -2048, 32768, 0);
    setCh(1, -2048, 2047, 65535, 0);
    runCal(1'b1, 1'b0);
    check("sat_pos0", outCh(0), 3000);
    check("sat_neg1", outCh(1), -3000);
    check("sat_flags", oSat, 2'b11);
    setCh(0, -2048, 2047, 32768, 0);
    setCh(1, 2047, -2048, 65535, 0);
    runCal(1'b0, 1'b0);
    check("sat_neg0", outCh(0), -3000);
    check("sat_pos1", outCh(1), 3000);
    check("sat_flags2", oSat, 2'b11);

    // Anti-windup: Ki = 1.0, L = 100, e = +50 ten times, then -50, then e = 0 with L = 3000
    setCh(0, 50, 0, 0, 4096);
    setCh(1, 0, 0, 0, 0);
    iOut_max = 15'd100;
    runCal(1'b1, 1'b0);
    check("aw_first", outCh(0), 50);
    repeat (9) runCal(1'b0, 1'b0);
    check("aw_tenth", outCh(0), 100);
    check("aw_tenth_sat", oSat, AW ? 0 : 1);
    setCh(0, 0, 50, 0, 4096);
    runCal(1'b0, 1'b0);
    check("aw_reverse", outCh(0), AW ? 50 : 100);
    check("aw_reverse_sat", oSat, AW ? 0 : 1);
    setCh(0, 0, 0, 0, 4096);
    iOut_max = 15'd3000;
    runCal(1'b0, 1'b0);
    check("aw_integ", outCh(0), AW ? 50 : 450);

    // L = 0: outputs forced to 0
    setCh(0, 50, 0, 0, 4096);
    iOut_max = 15'd0;
    runCal(1'b1, 1'b0);
    runCal(1'b0, 1'b0);
    check("l0_out", outCh(0), 0);
    check("l0_sat", oSat, AW ? 0 : 1);
    setCh(0, 0, 0, 0, 4096);
    iOut_max = 15'd3000;
    runCal(1'b0, 1'b0);
    check("l0_integ", outCh(0), AW ? 0 : 100);

    // Start at N+3 is ignored
    iCal_en = 1'b1;
    @(posedge iClk); #1;
    iCal_en = 1'b0;
    repeat (2) @(posedge iClk);
    #1;
    iCal_en = 1'b1;
    @(posedge iClk); #1;
    iCal_en = 1'b0;
    strobes = 0;
    repeat (25) begin
      if (oCal_done) strobes++;
      @(posedge iClk); #1;
    end
    check("coll_strobes", strobes, 1);
    check("coll_idle", oBusy, 0);

    // Clear with start, and clear pending while busy
    setCh(0, 0, 0, 0, 0);
    setCh(1, 10, 0, 0, 2048);
    runCal(1'b1, 1'b0);
    runCal(1'b0, 1'b0);
    check("clr_pre", outCh(1), 10);
    runCal(1'b1, 1'b0);
    check("clr_with_start", outCh(1), 5);
    runCal(1'b0, 1'b1);
    check("clr_pending_unaffected", outCh(1), 10);
    runCal(1'b0, 1'b0);
    check("clr_pending_applied", outCh(1), 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
